// File: rtl/lock_dialer.sv
// lock_dialer: plays a 6-digit code into the lock over num/enter/lock_reset, classifies the hex0..hex5 display as OPEN/CLOSED/fault, and optionally sweeps the code in BCD
module lock_dialer #(
  parameter int SETUP_CYCLES = 2,
  parameter int PULSE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sweep,
  input  logic [23:0] code,
  input  logic [6:0]  hex0,
  input  logic [6:0]  hex1,
  input  logic [6:0]  hex2,
  input  logic [6:0]  hex3,
  input  logic [6:0]  hex4,
  input  logic [6:0]  hex5,
  output logic [3:0]  num,
  output logic        enter,
  output logic        lock_reset,
  output logic        busy,
  output logic        done,
  output logic        opened,
  output logic        fault,
  output logic [23:0] cur_code
);
  localparam int T = 2 * SETUP_CYCLES + PULSE_CYCLES;
  localparam int CW = $clog2(T + 1);
  localparam logic [41:0] OPEN_PAT = {7'b1111111, 7'b1111111, 7'b1000000, 7'b0001100, 7'b0000110, 7'b0101011};
  localparam logic [41:0] CLOSED_PAT = {7'b1000110, 7'b1000111, 7'b1000000, 7'b0010010, 7'b0000110, 7'b1000000};
  typedef enum logic [2:0] {IDLE, RST, DIGIT, CHECK, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic sweep_q, sweep_n;
  logic [23:0] code_n, inc;
  logic [3:0] num_n;
  logic enter_n, lock_reset_n, busy_n, done_n, opened_n, fault_n, bad, c;
  logic [41:0] disp;
  assign disp = {hex5, hex4, hex3, hex2, hex1, hex0};
  always_comb begin
    inc = cur_code;
    bad = 1'b0;
    c = 1'b1;
    for (int i = 0; i < 6; i++) begin
      inc[4*i +: 4] = c ? (cur_code[4*i +: 4] == 4'd9 ? 4'd0 : cur_code[4*i +: 4] + 4'd1) : cur_code[4*i +: 4];
      c = c & (cur_code[4*i +: 4] == 4'd9);
      bad = bad | (code[4*i +: 4] > 4'd9);
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    idx_n = idx;
    sweep_n = sweep_q;
    code_n = cur_code;
    busy_n = busy;
    done_n = done;
    opened_n = opened;
    fault_n = fault;
    case (state)
      IDLE, DONE: begin
        cnt_n = '0;
        if (start) begin
          code_n = code;
          sweep_n = sweep;
          idx_n = '0;
          done_n = sweep && bad;
          opened_n = 1'b0;
          fault_n = sweep && bad;
          busy_n = !(sweep && bad);
          state_n = (sweep && bad) ? DONE : RST;
        end
      end
      RST: if (cnt == CW'(T - 1)) begin
        cnt_n = '0;
        idx_n = '0;
        state_n = DIGIT;
      end
      DIGIT: if (cnt == CW'(T - 1)) begin
        cnt_n = '0;
        idx_n = idx + 3'd1;
        state_n = idx == 3'd5 ? CHECK : DIGIT;
      end
      default: if (cnt == CW'(SETUP_CYCLES - 1)) begin
        cnt_n = '0;
        if (disp == CLOSED_PAT && sweep_q && cur_code != 24'h999999) begin
          code_n = inc;
          state_n = RST;
        end else begin
          state_n = DONE;
          busy_n = 1'b0;
          done_n = 1'b1;
          opened_n = disp == OPEN_PAT;
          fault_n = disp != OPEN_PAT && disp != CLOSED_PAT;
        end
      end
    endcase
    // Strobe outputs are computed from the next phase position so they leave a flop
    lock_reset_n = state_n == RST;
    enter_n = (state_n == RST || state_n == DIGIT) && cnt_n >= CW'(SETUP_CYCLES) && cnt_n < CW'(SETUP_CYCLES + PULSE_CYCLES);
    num_n = state_n == DIGIT ? code_n[5'd20 - {idx_n, 2'b00} +: 4] : 4'd0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sweep_q <= 1'b0;
      cur_code <= '0;
      num <= '0;
      enter <= 1'b0;
      lock_reset <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      opened <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sweep_q <= sweep_n;
      cur_code <= code_n;
      num <= num_n;
      enter <= enter_n;
      lock_reset <= lock_reset_n;
      busy <= busy_n;
      done <= done_n;
      opened <= opened_n;
      fault <= fault_n;
    end
  end
endmodule

// File: tb/tb_lock_dialer.sv
// tb_lock_dialer: directed scoreboard bench for lock_dialer against a behavioural lock model
module tb_lock_dialer;
  localparam logic [41:0] OPEN_PAT = {7'b1111111, 7'b1111111, 7'b1000000, 7'b0001100, 7'b0000110, 7'b0101011};
  localparam logic [41:0] CLOSED_PAT = {7'b1000110, 7'b1000111, 7'b1000000, 7'b0010010, 7'b0000110, 7'b1000000};
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, sweep = 1'b0;
  logic [23:0] code = '0, cur_code;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic [3:0] num;
  logic enter, lock_reset, busy, done, opened, fault;
  int vectors = 0, errors = 0, pulses = 0;
  typedef struct {int edges; logic o; logic f; logic [23:0] cur;} exp_t;
  exp_t exp_q[$];
  logic [3:0] num_q[$];
  logic [23:0] secret = 24'h722297, entered = '0;
  int count = 0;
  logic stuck = 1'b0, enter_d = 1'b0, enter_p = 1'b0;
  logic [3:0] num_rise = '0;
  lock_dialer dut (
    .clk(clk), .reset(reset), .start(start), .sweep(sweep), .code(code),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
    .num(num), .enter(enter), .lock_reset(lock_reset), .busy(busy), .done(done),
    .opened(opened), .fault(fault), .cur_code(cur_code)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    enter_d <= enter;
    if (enter && !enter_d) begin
      if (lock_reset) begin
        entered <= '0;
        count <= 0;
      end else begin
        entered <= {entered[19:0], num};
        count <= count + 1;
      end
    end
  end
  always_comb begin
    {hex5, hex4, hex3, hex2, hex1, hex0} = CLOSED_PAT;
    if (stuck) {hex5, hex4, hex3, hex2, hex1, hex0} = {35'h7ffffffff, 7'b0100100};
    else if (count == 6 && entered == secret) {hex5, hex4, hex3, hex2, hex1, hex0} = OPEN_PAT;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (enter && !enter_p) begin
      pulses++;
      num_rise = num;
      if (num_q.size() > 0) chk("num_seq", {28'd0, num}, {28'd0, num_q.pop_front()});
    end else if (enter && enter_p) chk("num_stable", {28'd0, num}, {28'd0, num_rise});
    enter_p = enter;
  end
  task automatic run(input logic [23:0] c, input logic sw, input int ee, input logic eo, input logic ef, input logic [23:0] ecur);
    int n;
    exp_t e;
    exp_q.push_back('{ee, eo, ef, ecur});
    @(negedge clk);
    code = c;
    sweep = sw;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 2000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    e = exp_q.pop_front();
    chk("done_edges", n, e.edges);
    chk("opened", {31'd0, opened}, {31'd0, e.o});
    chk("fault", {31'd0, fault}, {31'd0, e.f});
    chk("cur_code", {8'd0, cur_code}, {8'd0, e.cur});
    chk("busy_low", {31'd0, busy}, 32'd0);
  endtask
  task automatic chk_zero(input string tag);
    chk(tag, {num, enter, lock_reset, busy, done, opened, fault, cur_code}, 32'd0);
  endtask
  initial begin
    int p0, n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset_state");
    reset = 1'b0;
    p0 = pulses;
    run(24'h722297, 1'b0, 44, 1'b1, 1'b0, 24'h722297);
    chk("pulses_single", pulses - p0, 7);
    run(24'h722298, 1'b0, 44, 1'b0, 1'b0, 24'h722298);
    num_q = '{4'd0, 4'd7, 4'd2, 4'd2, 4'd2, 4'd9, 4'd0};
    run(24'h722290, 1'b1, 352, 1'b1, 1'b0, 24'h722297);
    chk("num_q_drained", num_q.size(), 0);
    secret = 24'h100000;
    run(24'h099999, 1'b1, 88, 1'b1, 1'b0, 24'h100000);
    secret = 24'h722297;
    run(24'h999999, 1'b1, 44, 1'b0, 1'b0, 24'h999999);
    p0 = pulses;
    run(24'h72229A, 1'b1, 0, 1'b0, 1'b1, 24'h72229A);
    repeat (3) @(negedge clk);
    chk("no_enter_illegal", pulses - p0, 0);
    stuck = 1'b1;
    run(24'h722297, 1'b0, 44, 1'b0, 1'b1, 24'h722297);
    stuck = 1'b0;
    @(negedge clk);
    code = 24'h722297;
    sweep = 1'b0;
    start = 1'b1;
    p0 = pulses;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(enter && pulses - p0 == 4) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_pulse_reached", {31'd0, enter}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk_zero("reset_mid_pulse");
    reset = 1'b0;
    run(24'h722297, 1'b0, 44, 1'b1, 1'b0, 24'h722297);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
